// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1:2 TDM demultiplexer.
package tdm_demux_pkg;

    // Framing state: IDLE discards din until fsync, RUN captures every slot.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WORD_W_DEF = 4;

endpackage

// File: rtl/deser_lsb.sv
// LSB-first deserializer: one addressed bit written per enabled cycle, with
// a clear that takes effect together with that cycle's bit write.
module deser_lsb #(
    parameter int WORD_W = 4,
    parameter int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_din,
    output logic [WORD_W-1:0] o_q,
    output logic [WORD_W-1:0] o_nxt
);

    logic [WORD_W-1:0] r_q;
    logic [WORD_W-1:0] w_nxt;

    // Next contents: optionally cleared, then the addressed bit overwritten.
    always_comb begin
        w_nxt = i_clr ? '0 : r_q;
        if (i_en) begin
            w_nxt[i_idx] = i_din;
        end
    end

    // Shift/load register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_nxt;
        end
    end

    assign o_q   = r_q;
    // The top loads the finished word from here so the last bit is included.
    assign o_nxt = w_nxt;

endmodule

// File: rtl/tdm_demux_1_2.sv
// 1:2 TDM demultiplexer: even slots feed channel A, odd slots channel B,
// LSB first, frames of 2*WORD_W slots aligned by fsync.
//
// state | meaning
// IDLE  | discard din, wait for fsync (fsync cycle itself is A bit 0)
// RUN   | capture one slot per cycle, free-running frame counter
module tdm_demux_1_2
    import tdm_demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              fsync,
    output logic [WORD_W-1:0] a_word,
    output logic              a_valid,
    output logic [WORD_W-1:0] b_word,
    output logic              b_valid,
    output logic              sel_out,
    output logic              err
);

    localparam int SLOT_N = 2 * WORD_W;
    localparam int SLOT_W = $clog2(SLOT_N);
    localparam int IDX_W  = SLOT_W - 1;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [WORD_W-1:0]   r_a_word;
    logic [WORD_W-1:0]   r_b_word;
    logic                r_a_valid;
    logic                r_b_valid;
    logic                r_sel;
    logic                r_err;

    logic                w_capture;
    logic [SLOT_W-1:0]   w_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic                w_resync_err;
    logic                w_last_a;
    logic                w_last_b;
    logic [WORD_W-1:0]   w_a_q;
    logic [WORD_W-1:0]   w_b_q;
    logic [WORD_W-1:0]   w_a_nxt;
    logic [WORD_W-1:0]   w_b_nxt;

    // Slot decode: any fsync (from IDLE or mid-frame) realigns this sample to slot 0.
    always_comb begin
        w_capture    = (r_state == RUN) || fsync;
        w_slot       = fsync ? '0 : r_slot;
        w_resync_err = (r_state == RUN) && fsync && (r_slot != '0);
        w_last_a     = (w_slot == SLOT_W'(SLOT_N - 2));
        w_last_b     = (w_slot == SLOT_W'(SLOT_N - 1));
        w_slot_nxt   = w_last_b ? '0 : (w_slot + SLOT_W'(1));
    end

    // fsync clears both partial words, so a resync never leaks stale bits.
    deser_lsb #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_deser_a (
        .clk   (clk),
        .rst   (rst),
        .i_clr (fsync),
        .i_en  (w_capture && !w_slot[0]),
        .i_idx (w_slot[SLOT_W-1:1]),
        .i_din (din),
        .o_q   (w_a_q),
        .o_nxt (w_a_nxt)
    );

    deser_lsb #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_deser_b (
        .clk   (clk),
        .rst   (rst),
        .i_clr (fsync),
        .i_en  (w_capture && w_slot[0]),
        .i_idx (w_slot[SLOT_W-1:1]),
        .i_din (din),
        .o_q   (w_b_q),
        .o_nxt (w_b_nxt)
    );

    // Framing FSM with registered words, valid pulses, channel select and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_a_word  <= '0;
            r_b_word  <= '0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_sel     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_err     <= 1'b0;
            if (w_capture) begin
                r_state <= RUN;
                r_slot  <= w_slot_nxt;
                r_sel   <= w_slot_nxt[0];
                r_err   <= w_resync_err;
                if (w_last_a) begin
                    r_a_word  <= w_a_nxt;
                    r_a_valid <= 1'b1;
                end
                if (w_last_b) begin
                    r_b_word  <= w_b_nxt;
                    r_b_valid <= 1'b1;
                end
            end else begin
                r_sel <= 1'b0;
            end
        end
    end

    assign a_word  = r_a_word;
    assign b_word  = r_b_word;
    assign a_valid = r_a_valid;
    assign b_valid = r_b_valid;
    assign sel_out = r_sel;
    assign err     = r_err;

endmodule
